// File: rtl/cache_system_if.sv
// Requester-side access bus for cache_system: address/request in, data and hit flags out.
interface cache_system_if #(
    parameter int DATA_W = 11
) ();
    logic [10:0]       addr;
    logic              read;
    logic [DATA_W-1:0] read_data;
    logic              l1_hit;
    logic              l2_hit;

    modport master (output addr, read, input read_data, l1_hit, l2_hit);
    modport slave  (input addr, read, output read_data, l1_hit, l2_hit);
endinterface

// File: rtl/cache_system.sv
// Read-only two-level cache (8-line L1, 32-line L2) over an identity backing memory,
// set-associative with true-LRU ranks; one cache_level instance per level.
module cache_level #(
    parameter int SETS   = 8,
    parameter int WAYS   = 1,
    parameter int DATA_W = 11
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en_i,
    input  logic [10:0]       addr_i,
    input  logic [DATA_W-1:0] fill_data_i,
    output logic              hit_o,
    output logic [DATA_W-1:0] hit_data_o
);
    localparam int IDX_W = $clog2(SETS);
    localparam int TAG_W = 11 - IDX_W;
    localparam int WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1;
    typedef logic [WAY_W-1:0] way_t;

    logic [SETS-1:0][WAYS-1:0]              vld_q;
    logic [SETS-1:0][WAYS-1:0][TAG_W-1:0]   tag_q;
    logic [SETS-1:0][WAYS-1:0][DATA_W-1:0]  data_q;
    logic [SETS-1:0][WAYS-1:0][WAY_W-1:0]   age_q;

    logic [IDX_W-1:0] idx;
    logic [TAG_W-1:0] tag;
    logic             inv_found;
    way_t             hit_way, vict, touch, old_age;

    assign idx = addr_i[IDX_W-1:0];
    assign tag = addr_i[10:IDX_W];

    always_comb begin
        hit_o      = 1'b0;
        hit_way    = '0;
        hit_data_o = '0;
        inv_found  = 1'b0;
        vict       = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (vld_q[idx][w] && tag_q[idx][w] == tag) begin
                hit_o      = 1'b1;
                hit_way    = way_t'(w);
                hit_data_o = data_q[idx][w];
            end
        end
        // Descending scan so the lowest-index invalid way wins.
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (!vld_q[idx][w]) begin
                inv_found = 1'b1;
                vict      = way_t'(w);
            end
        end
        if (!inv_found) begin
            for (int w = 0; w < WAYS; w++) begin
                if (age_q[idx][w] == way_t'(WAYS - 1)) vict = way_t'(w);
            end
        end
        touch = hit_o ? hit_way : vict;
        // An invalid way counts as oldest so every valid way ages and ranks stay a permutation.
        old_age = vld_q[idx][touch] ? age_q[idx][touch] : way_t'(WAYS - 1);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vld_q  <= '0;
            tag_q  <= '0;
            data_q <= '0;
            age_q  <= '0;
        end else if (en_i) begin
            for (int w = 0; w < WAYS; w++) begin
                if (way_t'(w) == touch)
                    age_q[idx][w] <= '0;
                else if (vld_q[idx][w] && age_q[idx][w] < old_age)
                    age_q[idx][w] <= age_q[idx][w] + 1'b1;
            end
            if (!hit_o) begin
                vld_q[idx][touch]  <= 1'b1;
                tag_q[idx][touch]  <= tag;
                data_q[idx][touch] <= fill_data_i;
            end
        end
    end
endmodule

module cache_system #(
    parameter int WAYS   = 1,
    parameter int DATA_W = 11
) (
    input  logic           clk,
    input  logic           rst,
    cache_system_if.slave  bus
);
    logic              l1_hit, l2_hit;
    logic [DATA_W-1:0] l1_data, l2_data, mem_word, l1_fill, read_data_d;
    logic [DATA_W-1:0] read_data_q;
    logic              l1_hit_q, l2_hit_q;

    assign mem_word    = DATA_W'(bus.addr);
    assign l1_fill     = l2_hit ? l2_data : mem_word;
    assign read_data_d = l1_hit ? l1_data : l1_fill;

    cache_level #(.SETS(8 / WAYS), .WAYS(WAYS), .DATA_W(DATA_W)) u_l1 (
        .clk(clk), .rst(rst), .en_i(bus.read), .addr_i(bus.addr),
        .fill_data_i(l1_fill), .hit_o(l1_hit), .hit_data_o(l1_data)
    );

    // L2 is only consulted (and its LRU touched) when L1 misses.
    cache_level #(.SETS(32 / WAYS), .WAYS(WAYS), .DATA_W(DATA_W)) u_l2 (
        .clk(clk), .rst(rst), .en_i(bus.read && !l1_hit), .addr_i(bus.addr),
        .fill_data_i(mem_word), .hit_o(l2_hit), .hit_data_o(l2_data)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            read_data_q <= '0;
            l1_hit_q    <= 1'b0;
            l2_hit_q    <= 1'b0;
        end else if (bus.read) begin
            read_data_q <= read_data_d;
            l1_hit_q    <= l1_hit;
            l2_hit_q    <= l2_hit && !l1_hit;
        end
    end

    assign bus.read_data = read_data_q;
    assign bus.l1_hit    = l1_hit_q;
    assign bus.l2_hit    = l2_hit_q;
endmodule

// File: tb/tb_cache_system.sv
// Drives the direct-mapped, 2-way and 4-way variants in lockstep and checks each against
// an MRU-ordered list model of L1/L2 contents.
module tb_cache_system;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [10:0] addr = '0;
    logic        read = 1'b0;

    always #5 clk = ~clk;

    cache_system_if #(.DATA_W(11)) if1 ();
    cache_system_if #(.DATA_W(11)) if2 ();
    cache_system_if #(.DATA_W(32)) if4 ();

    assign if1.addr = addr;  assign if1.read = read;
    assign if2.addr = addr;  assign if2.read = read;
    assign if4.addr = addr;  assign if4.read = read;

    cache_system #(.WAYS(1), .DATA_W(11)) u_w1 (.clk(clk), .rst(rst), .bus(if1.slave));
    cache_system #(.WAYS(2), .DATA_W(11)) u_w2 (.clk(clk), .rst(rst), .bus(if2.slave));
    cache_system #(.WAYS(4), .DATA_W(32)) u_w4 (.clk(clk), .rst(rst), .bus(if4.slave));

    logic [31:0] act_d  [3];
    logic        act_l1 [3];
    logic        act_l2 [3];
    assign act_d[0] = 32'(if1.read_data); assign act_l1[0] = if1.l1_hit; assign act_l2[0] = if1.l2_hit;
    assign act_d[1] = 32'(if2.read_data); assign act_l1[1] = if2.l1_hit; assign act_l2[1] = if2.l2_hit;
    assign act_d[2] = if4.read_data;      assign act_l1[2] = if4.l1_hit; assign act_l2[2] = if4.l2_hit;

    int ntests = 0;
    int nfail  = 0;
    int ways_of [3] = '{1, 2, 4};

    // lm[2k] = L1 of variant k, lm[2k+1] = L2; each list is most-recent first.
    int unsigned lm [6][$];
    logic        exp_l1 [3];
    logic        exp_l2 [3];
    logic [31:0] exp_d  [3];

    task automatic model_reset();
        for (int q = 0; q < 6; q++) lm[q].delete();
        for (int k = 0; k < 3; k++) begin
            exp_l1[k] = 1'b0; exp_l2[k] = 1'b0; exp_d[k] = '0;
        end
    endtask

    task automatic model_level(input int q, input int nsets, input int w,
                               input int unsigned a, output bit hit);
        int pos = -1;
        int cnt = 0;
        int last = -1;
        for (int i = 0; i < lm[q].size(); i++) begin
            if (lm[q][i] == a) pos = i;
            if (lm[q][i] % nsets == a % nsets) begin cnt++; last = i; end
        end
        hit = (pos >= 0);
        if (hit) lm[q].delete(pos);
        else if (cnt == w) lm[q].delete(last);
        lm[q].push_front(a);
    endtask

    task automatic access(input int unsigned a);
        bit h1, h2;
        @(negedge clk);
        addr = 11'(a);
        read = 1'b1;
        @(posedge clk);
        #1 read = 1'b0;
        for (int k = 0; k < 3; k++) begin
            model_level(2 * k, 8 / ways_of[k], ways_of[k], a, h1);
            h2 = 1'b0;
            if (!h1) model_level(2 * k + 1, 32 / ways_of[k], ways_of[k], a, h2);
            exp_l1[k] = h1; exp_l2[k] = h2; exp_d[k] = a;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        model_reset();
    endtask

    task automatic test_reset();
        rst  = 1'b0;
        addr = 11'h010;
        read = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        model_reset();
        for (int k = 0; k < 3; k++) begin
            ntests++;
            if ({act_l1[k], act_l2[k], act_d[k]} !== {exp_l1[k], exp_l2[k], exp_d[k]}) begin
                nfail++;
                $display("FAIL reset w=%0d: got l1=%b l2=%b d=%h, want 0 0 0", ways_of[k], act_l1[k], act_l2[k], act_d[k]);
            end
        end
        @(negedge clk);
        read = 1'b0;
        rst  = 1'b1;
    endtask

    task automatic test_cold_miss();
        do_reset();
        for (int r = 0; r < 2; r++) begin
            access(32'h010);
            for (int k = 0; k < 3; k++) begin
                ntests++;
                if ({act_l1[k], act_l2[k], act_d[k]} !== {1'(r), 1'b0, 32'h010}) begin
                    nfail++;
                    $display("FAIL cold_miss w=%0d rd=%0d: got l1=%b l2=%b d=%h, want l1=%0d l2=0 d=010",
                             ways_of[k], r, act_l1[k], act_l2[k], act_d[k], r);
                end
            end
        end
    endtask

    task automatic test_stride();
        do_reset();
        for (int s = 0; s < 2; s++) begin
            for (int i = 0; i < 16; i++) begin
                access(32'(16 * i));
                for (int k = 0; k < 3; k++) begin
                    ntests++;
                    if ({act_l1[k], act_l2[k], act_d[k]} !== {exp_l1[k], exp_l2[k], exp_d[k]} ||
                        (s == 0 && (act_l1[k] || act_l2[k]))) begin
                        nfail++;
                        $display("FAIL stride w=%0d sweep=%0d a=%h: got l1=%b l2=%b d=%h, want l1=%b l2=%b d=%h",
                                 ways_of[k], s, 16 * i, act_l1[k], act_l2[k], act_d[k], exp_l1[k], exp_l2[k], exp_d[k]);
                    end
                end
            end
        end
    endtask

    // Directed sequence checked against the model, plus one fixed expectation for a chosen variant.
    task automatic run_directed(input string name, input int unsigned seq[], input int kk,
                                input logic [1:0] want[]);
        do_reset();
        for (int i = 0; i < seq.size(); i++) begin
            access(seq[i]);
            for (int k = 0; k < 3; k++) begin
                ntests++;
                if ({act_l1[k], act_l2[k], act_d[k]} !== {exp_l1[k], exp_l2[k], exp_d[k]}) begin
                    nfail++;
                    $display("FAIL %s w=%0d step=%0d: got l1=%b l2=%b d=%h, want l1=%b l2=%b d=%h",
                             name, ways_of[k], i, act_l1[k], act_l2[k], act_d[k], exp_l1[k], exp_l2[k], exp_d[k]);
                end
            end
            if (want[i] != 2'b11) begin
                ntests++;
                if ({act_l1[kk], act_l2[kk]} !== want[i]) begin
                    nfail++;
                    $display("FAIL %s_fixed w=%0d step=%0d: got l1/l2=%b, want %b",
                             name, ways_of[kk], i, {act_l1[kk], act_l2[kk]}, want[i]);
                end
            end
        end
    endtask

    task automatic test_conflict();
        run_directed("conflict", '{0, 8, 0, 0}, 0, '{2'b00, 2'b00, 2'b01, 2'b10});
    endtask

    task automatic test_lru();
        run_directed("lru2", '{0, 4, 8, 0, 8, 4}, 1, '{2'b11, 2'b11, 2'b11, 2'b01, 2'b10, 2'b01});
        run_directed("lru4", '{0, 2, 4, 6, 0, 8, 2, 0}, 2,
                     '{2'b11, 2'b11, 2'b11, 2'b11, 2'b10, 2'b00, 2'b01, 2'b10});
    endtask

    task automatic test_reset_mid();
        do_reset();
        access(32'h005);
        access(32'h005);
        @(negedge clk);
        #1 rst = 1'b0;
        #1;
        model_reset();
        for (int k = 0; k < 3; k++) begin
            ntests++;
            if ({act_l1[k], act_l2[k], act_d[k]} !== 34'b0) begin
                nfail++;
                $display("FAIL reset_async w=%0d: got l1=%b l2=%b d=%h, want 0 0 0", ways_of[k], act_l1[k], act_l2[k], act_d[k]);
            end
        end
        #1 rst = 1'b1;
        access(32'h005);
        for (int k = 0; k < 3; k++) begin
            ntests++;
            if ({act_l1[k], act_l2[k], act_d[k]} !== {1'b0, 1'b0, 32'h005}) begin
                nfail++;
                $display("FAIL reset_miss w=%0d: got l1=%b l2=%b d=%h, want 0 0 005", ways_of[k], act_l1[k], act_l2[k], act_d[k]);
            end
        end
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            addr = 11'($urandom_range(0, 2047));
            @(posedge clk);
            #1;
            for (int k = 0; k < 3; k++) begin
                ntests++;
                if ({act_l1[k], act_l2[k], act_d[k]} !== {exp_l1[k], exp_l2[k], exp_d[k]}) begin
                    nfail++;
                    $display("FAIL hold w=%0d cyc=%0d: got l1=%b l2=%b d=%h, want l1=%b l2=%b d=%h",
                             ways_of[k], c, act_l1[k], act_l2[k], act_d[k], exp_l1[k], exp_l2[k], exp_d[k]);
                end
            end
        end
        access(32'h005);
        for (int k = 0; k < 3; k++) begin
            ntests++;
            if ({act_l1[k], act_l2[k], act_d[k]} !== {1'b1, 1'b0, 32'h005}) begin
                nfail++;
                $display("FAIL rehit w=%0d: got l1=%b l2=%b d=%h, want 1 0 005", ways_of[k], act_l1[k], act_l2[k], act_d[k]);
            end
        end
    endtask

    // Back-to-back random accesses over a small pool (to force reuse and evictions),
    // with occasional idle cycles and far addresses.
    task automatic test_random();
        int unsigned a;
        do_reset();
        for (int i = 0; i < 400; i++) begin
            a = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 2047) : $urandom_range(0, 95);
            if ($urandom_range(0, 7) == 0) @(negedge clk);
            access(a);
            for (int k = 0; k < 3; k++) begin
                ntests++;
                if ({act_l1[k], act_l2[k], act_d[k]} !== {exp_l1[k], exp_l2[k], exp_d[k]}) begin
                    nfail++;
                    $display("FAIL random w=%0d i=%0d a=%h: got l1=%b l2=%b d=%h, want l1=%b l2=%b d=%h",
                             ways_of[k], i, a, act_l1[k], act_l2[k], act_d[k], exp_l1[k], exp_l2[k], exp_d[k]);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_cold_miss();
        test_stride();
        test_conflict();
        test_lru();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end
endmodule

// File: doc/cache_system.md
# cache_system

Read-only two-level (L1 + L2) cache model with an internal backing memory, parameterised by associativity. Instantiated with WAYS=1, 2 or 4, it provides direct-mapped, 2-way and 4-way variants behind one common interface. It sits between an address-generating requester and the memory model. It reports per-access whether the word came from L1, from L2, or from memory.

## Interface
- WAYS, 1: associativity of both levels; legal values 1, 2, 4.
- DATA_W, 11: data word width; must be ≥ 11. Use 11 for the direct and 2-way variants, 32 for the 4-way variant.
- clk  input  1  clock; all state changes on the rising edge.
- rst  input  1  reset; asynchronous and active-low.
- addr  input  11  word address of the access.
- read  input  1  access request, sampled on each rising clk edge.
- read_data  output  DATA_W  data returned by the last accepted access.
- l1_hit  output  1  last accepted access hit in L1.
- l2_hit  output  1  last accepted access missed L1 and hit L2.

## Operation
- Block size is one word; every line holds one tag, one data word and one valid bit.
- Backing memory is combinational: the word at address A is A, zero-extended to DATA_W.
- L1 has 8 lines, organised as 8/WAYS sets of WAYS ways.
  - Set index = addr[log2(8/WAYS)-1:0]; tag = the remaining upper bits.
  - WAYS=4 uses index addr[0]; WAYS=1 uses index addr[2:0].
- L2 has 32 lines, organised as 32/WAYS sets of WAYS ways, indexed the same way.
- Lookup on an accepted access (read=1 at a rising edge):
  - L1 hit: l1_hit=1, l2_hit=0, read_data = L1 data. No fills. L1 LRU is updated.
  - L1 miss, L2 hit: l1_hit=0, l2_hit=1, read_data = L2 data. The line is filled into L1. L2 LRU and L1 LRU are updated.
  - Miss in both: l1_hit=0, l2_hit=0, read_data = memory word. The line is filled into both L2 and L1.
- Victim selection, applied per set: take the lowest-index invalid way first; otherwise take the least-recently-used way.
- LRU is true LRU, kept as an age rank per way.
  - On a hit or fill, the touched way becomes age 0.
  - Ways younger than the touched way's old age increment by one.
  - WAYS=1 needs no LRU state.
- Policy is non-inclusive with no back-invalidation: an L2 eviction leaves any L1 copy intact.
- Data is never modified, so no dirty state or write-back exists.
- l1_hit and l2_hit are never both 1.

## Timing
- Single-cycle latency: for an access sampled at edge N, the outputs and all cache/LRU updates are registered at edge N.
- Outputs are valid after edge N and hold until the next accepted access.
- With read=0, no state or output changes.
- Back-to-back accesses on consecutive edges are legal. Each access sees the state left by the previous one.
- Reset (rst=0), asynchronous and taking effect immediately:
  - All valid bits and LRU ages are cleared.
  - read_data=0, l1_hit=0, l2_hit=0.
  - Accesses are ignored while rst=0.
  - Reset asserted between accesses discards all cached contents; the next access is a full miss.
- An addr change without read=1 has no effect.

## Test plan
- Cold miss, each WAYS: after reset, read addr 0x010 → l1_hit=0, l2_hit=0, read_data=0x010. An immediate re-read of 0x010 → l1_hit=1, read_data=0x010.
- Stride sweep, each WAYS: read 0, 16, 32 … 240 once after reset → 16 misses (0 hits). A second sweep gives WAYS-dependent L1/L2 hits that match a reference model; read_data always equals addr.
- Conflict to L2, WAYS=1: read 0, 8, 0 → the third access has l1_hit=0, l2_hit=1, read_data=0. A fourth read of 0 → l1_hit=1.
- LRU, WAYS=2: read 0, 4, 8, 0:
  - The 4th access gives l2_hit=1, because 0 was the LRU way and was evicted.
  - A following read of 8 → l1_hit=1.
  - A following read of 4 → l2_hit=1.
- LRU, WAYS=4: read 0, 2, 4, 6, 0, 8 (all in L1 set 0):
  - The 5th access gives l1_hit=1.
  - The 6th access evicts 2.
  - A following read of 2 → l2_hit=1; a following read of 0 → l1_hit=1.
- Reset mid-run: warm address 0x005, pulse rst low for less than one clock, then read 0x005 → full miss. With read=0 for 3 cycles, the outputs hold their values.
